// File: rtl/cfo_comp.sv
// Carrier frequency offset compensation.
// Each sample after cs_start is de-rotated by a phase that grows linearly
// with the sample index. The rotation is done by a pipelined rotation-mode
// CORDIC: a quadrant pre-rotation stage, STAGES micro-rotation stages, and
// a final gain-correction stage. Latency from di to do is STAGES+3 cycles.
module cfo_comp #(
   parameter int N       = 64,
   parameter int LOG2N   = 6,
   parameter int STAGES  = 14,
   parameter int MAX_LEN = 8192
) (
   input  logic               clk,
   input  logic               rst,
   input  logic signed [11:0] di_re,
   input  logic signed [11:0] di_im,
   input  logic               cs_start,
   input  logic signed [17:0] cfo_estimated,
   input  logic               cfo_estimated_vld,
   output logic signed [11:0] do_re,
   output logic signed [11:0] do_im,
   output logic               do_vld,
   output logic               do_start
);

   localparam int DATA_W = 12;                    // sample width
   localparam int COEF_W = 18;                    // angle width, 2Q15
   localparam int IW     = 16;                    // CORDIC datapath width
   localparam int SH     = $clog2(N);             // per-sample phase scaling
   localparam int PH_W   = COEF_W + LOG2N + 1;    // phase accumulator width
   localparam int CNT_W  = $clog2(MAX_LEN);

   localparam logic signed [PH_W-1:0]   PI_ACC     = PH_W'(102944 * (2 ** LOG2N));
   localparam logic signed [PH_W-1:0]   TWO_PI_ACC = PH_W'(205887 * (2 ** LOG2N));
   localparam logic signed [COEF_W-1:0] HALF_PI    = 18'sd51472;
   localparam logic signed [31:0]       GAIN_Q15   = 32'sd19899;
   localparam logic        [CNT_W-1:0]  LAST_CNT   = CNT_W'(MAX_LEN - 1);

   typedef enum logic {S_IDLE, S_ACTIVE} state_t;

   // atan(2^-i) in 2Q15, rounded; for i >= 5 it equals 2^(15-i) after rounding
   function automatic logic signed [COEF_W-1:0] atan_q15(input int i);
      case (i)
         0:       return 18'sd25736;
         1:       return 18'sd15193;
         2:       return 18'sd8027;
         3:       return 18'sd4075;
         4:       return 18'sd2045;
         default: return COEF_W'(32768 >> i);
      endcase
   endfunction

   // Keep the accumulated phase inside [-PI, PI]; one correction is enough
   function automatic logic signed [PH_W-1:0] wrap_phase(input logic signed [PH_W-1:0] v);
      if (v > PI_ACC)
         return v - TWO_PI_ACC;
      else if (v < -PI_ACC)
         return v + TWO_PI_ACC;
      else
         return v;
   endfunction

   // CORDIC gain correction: x * 0.60725 in Q15 with round-half-up
   function automatic logic signed [31:0] rnd_gain(input logic signed [IW-1:0] v);
      logic signed [31:0] p;
      p = $signed({{(32-IW){v[IW-1]}}, v}) * GAIN_Q15;
      return (p + 32'sd16384) >>> 15;
   endfunction

   // Clamp to the output sample range
   function automatic logic signed [DATA_W-1:0] sat_data(input logic signed [31:0] v);
      if (v > 32'sd2047)
         return 12'sd2047;
      else if (v < -32'sd2048)
         return -12'sd2048;
      else
         return v[DATA_W-1:0];
   endfunction

   // ---------------------------------------------------------------------
   // Control: CFO register, sample counter, phase accumulator
   // ---------------------------------------------------------------------
   logic signed [COEF_W-1:0] r_cfo;
   state_t                   r_state, w_state_nxt;
   logic        [CNT_W-1:0]  r_cnt, w_cnt_nxt;
   logic signed [PH_W-1:0]   r_phi, w_phi_nxt, w_phi_cur, w_delta;
   logic                     w_act, w_first;

   assign w_delta = -{{(PH_W-COEF_W){r_cfo[COEF_W-1]}}, r_cfo};

   // Capture a new estimate; it steers the phase increment from the next sample on
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_cfo <= '0;
      else if (cfo_estimated_vld)
         r_cfo <= cfo_estimated;
   end

   // FSM / counter / phase state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_phi   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_phi   <= w_phi_nxt;
      end
   end

   // Next state; cs_start restarts at sample 0 from any state, even on the last sample
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_phi_cur   = r_phi;
      w_act       = 1'b0;
      w_first     = 1'b0;
      if (cs_start) begin
         w_state_nxt = S_ACTIVE;
         w_cnt_nxt   = CNT_W'(1);
         w_phi_cur   = '0;
         w_act       = 1'b1;
         w_first     = 1'b1;
      end else if (r_state == S_ACTIVE) begin
         w_act = 1'b1;
         if (r_cnt == LAST_CNT) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
         end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
         end
      end
      w_phi_nxt = w_act ? wrap_phase(w_phi_cur + w_delta) : '0;
   end

   // ---------------------------------------------------------------------
   // Stage 1: input register, 16-bit data, 18-bit angle = phi >>> LOG2N
   // ---------------------------------------------------------------------
   logic signed [IW-1:0]     r_x_p0, r_y_p0;
   logic signed [COEF_W-1:0] r_z_p0;
   logic                     r_vld_p0, r_sof_p0;

   // Register the sample together with its rotation angle and flags
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_x_p0   <= '0;
         r_y_p0   <= '0;
         r_z_p0   <= '0;
         r_vld_p0 <= 1'b0;
         r_sof_p0 <= 1'b0;
      end else begin
         r_x_p0   <= {{(IW-DATA_W){di_re[DATA_W-1]}}, di_re};
         r_y_p0   <= {{(IW-DATA_W){di_im[DATA_W-1]}}, di_im};
         r_z_p0   <= w_phi_cur[SH+COEF_W-1:SH];
         r_vld_p0 <= w_act;
         r_sof_p0 <= w_first;
      end
   end

   // ---------------------------------------------------------------------
   // Stage 2: quadrant pre-rotation into the CORDIC convergence range
   // ---------------------------------------------------------------------
   logic signed [IW-1:0]     r_x_pr [0:STAGES];
   logic signed [IW-1:0]     r_y_pr [0:STAGES];
   logic signed [COEF_W-1:0] r_z_pr [0:STAGES];
   logic                     r_vld_pr [0:STAGES];
   logic                     r_sof_pr [0:STAGES];

   // Fold angles beyond +/-PI/2 by a fixed quarter turn
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_x_pr[0]   <= '0;
         r_y_pr[0]   <= '0;
         r_z_pr[0]   <= '0;
         r_vld_pr[0] <= 1'b0;
         r_sof_pr[0] <= 1'b0;
      end else begin
         r_vld_pr[0] <= r_vld_p0;
         r_sof_pr[0] <= r_sof_p0;
         if (r_z_p0 > HALF_PI) begin
            r_x_pr[0] <= -r_y_p0;
            r_y_pr[0] <= r_x_p0;
            r_z_pr[0] <= r_z_p0 - HALF_PI;
         end else if (r_z_p0 < -HALF_PI) begin
            r_x_pr[0] <= r_y_p0;
            r_y_pr[0] <= -r_x_p0;
            r_z_pr[0] <= r_z_p0 + HALF_PI;
         end else begin
            r_x_pr[0] <= r_x_p0;
            r_y_pr[0] <= r_y_p0;
            r_z_pr[0] <= r_z_p0;
         end
      end
   end

   // ---------------------------------------------------------------------
   // Stages 3..STAGES+2: micro-rotations, direction from residual angle sign
   // ---------------------------------------------------------------------
   for (genvar g = 0; g < STAGES; g++) begin : g_rot
      localparam logic signed [COEF_W-1:0] ATAN = atan_q15(g);

      // One CORDIC micro-rotation by +/-atan(2^-g)
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            r_x_pr[g+1]   <= '0;
            r_y_pr[g+1]   <= '0;
            r_z_pr[g+1]   <= '0;
            r_vld_pr[g+1] <= 1'b0;
            r_sof_pr[g+1] <= 1'b0;
         end else begin
            r_vld_pr[g+1] <= r_vld_pr[g];
            r_sof_pr[g+1] <= r_sof_pr[g];
            if (r_z_pr[g][COEF_W-1]) begin
               r_x_pr[g+1] <= r_x_pr[g] + (r_y_pr[g] >>> g);
               r_y_pr[g+1] <= r_y_pr[g] - (r_x_pr[g] >>> g);
               r_z_pr[g+1] <= r_z_pr[g] + ATAN;
            end else begin
               r_x_pr[g+1] <= r_x_pr[g] - (r_y_pr[g] >>> g);
               r_y_pr[g+1] <= r_y_pr[g] + (r_x_pr[g] >>> g);
               r_z_pr[g+1] <= r_z_pr[g] - ATAN;
            end
         end
      end
   end

   // ---------------------------------------------------------------------
   // Final stage: gain correction, rounding, saturation, output gating
   // ---------------------------------------------------------------------
   // Outputs are forced to zero whenever the slot carries no valid sample
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         do_re    <= '0;
         do_im    <= '0;
         do_vld   <= 1'b0;
         do_start <= 1'b0;
      end else begin
         do_vld   <= r_vld_pr[STAGES];
         do_start <= r_sof_pr[STAGES] & r_vld_pr[STAGES];
         if (r_vld_pr[STAGES]) begin
            do_re <= sat_data(rnd_gain(r_x_pr[STAGES]));
            do_im <= sat_data(rnd_gain(r_y_pr[STAGES]));
         end else begin
            do_re <= '0;
            do_im <= '0;
         end
      end
   end

endmodule

// File: tb/tb_cfo_comp.sv
// Directed testbench for cfo_comp.
// Every cycle the bench drives inputs #1 after the rising edge and, after the
// next rising edge, logs the outputs under the index of the edge that captured
// the inputs. The 17th register of the pipe updates 16 edges after the
// capturing edge, so sample k captured at log index s+k shows up at s+k+16
// (and is taken by the next block on the 17th edge).
module tb_cfo_comp;

   localparam int LAT     = 16;
   localparam int LOGN    = 12000;
   localparam int MAX_LEN = 8192;

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic signed [11:0] di_re = '0;
   logic signed [11:0] di_im = '0;
   logic               cs_start = 1'b0;
   logic signed [17:0] cfo_estimated = '0;
   logic               cfo_estimated_vld = 1'b0;
   logic signed [11:0] do_re, do_im;
   logic               do_vld, do_start;

   cfo_comp dut (
      .clk               (clk),
      .rst               (rst),
      .di_re             (di_re),
      .di_im             (di_im),
      .cs_start          (cs_start),
      .cfo_estimated     (cfo_estimated),
      .cfo_estimated_vld (cfo_estimated_vld),
      .do_re             (do_re),
      .do_im             (do_im),
      .do_vld            (do_vld),
      .do_start          (do_start)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;
   int cyc   = 0;

   logic signed [11:0] lg_re  [LOGN];
   logic signed [11:0] lg_im  [LOGN];
   logic               lg_vld [LOGN];
   logic               lg_sof [LOGN];

   task automatic chk(input string tag, input int got, input int exp, input int tol);
      n_chk++;
      if (got > exp + tol || got < exp - tol) begin
         n_err++;
         $display("FAIL %s got %0d want %0d (+/-%0d)", tag, got, exp, tol);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      if (cyc < LOGN) begin
         lg_re[cyc]  = do_re;
         lg_im[cyc]  = do_im;
         lg_vld[cyc] = do_vld;
         lg_sof[cyc] = do_start;
      end
      cyc++;
   endtask

   task automatic run(input int n);
      repeat (n) step();
   endtask

   function automatic int ore(input int i);
      return (i >= 0 && i < LOGN) ? int'(lg_re[i]) : 99999;
   endfunction
   function automatic int oim(input int i);
      return (i >= 0 && i < LOGN) ? int'(lg_im[i]) : 99999;
   endfunction
   function automatic int ovld(input int i);
      return (i >= 0 && i < LOGN) ? int'(lg_vld[i]) : 99;
   endfunction
   function automatic int osof(input int i);
      return (i >= 0 && i < LOGN) ? int'(lg_sof[i]) : 99;
   endfunction

   task automatic load_cfo(input int v);
      cfo_estimated     = 18'(v);
      cfo_estimated_vld = 1'b1;
      step();
      cfo_estimated_vld = 1'b0;
      step();
   endtask

   task automatic start(output int s);
      s        = cyc;
      cs_start = 1'b1;
      step();
      cs_start = 1'b0;
   endtask

   task automatic chk_smp(input string tag, input int s, input int k,
                          input int er, input int ei, input int tol);
      chk($sformatf("%s_k%0d_re", tag, k), ore(s + k + LAT), er, tol);
      chk($sformatf("%s_k%0d_im", tag, k), oim(s + k + LAT), ei, tol);
   endtask

   initial begin
      int s, s1, s2, base, cnt, nsof;

      // reset state
      run(3);
      chk("rst_re", int'(do_re), 0, 0);
      chk("rst_im", int'(do_im), 0, 0);
      chk("rst_vld", int'(do_vld), 0, 0);
      chk("rst_start", int'(do_start), 0, 0);
      rst = 1'b0;

      // zero CFO: output equals input, single start pulse 17 cycles later
      load_cfo(0);
      di_re = 12'sd1000;
      di_im = 12'sd0;
      start(s);
      run(70);
      chk("zero_start", osof(s + LAT), 1, 0);
      chk("zero_start_early", osof(s + LAT - 1), 0, 0);
      chk("zero_start_late", osof(s + LAT + 1), 0, 0);
      chk("zero_vld_early", ovld(s + LAT - 1), 0, 0);
      chk("zero_vld", ovld(s + LAT), 1, 0);
      for (int k = 0; k <= 40; k++) chk_smp("zero", s, k, 1000, 0, 2);

      // cfo = PI over 64 samples: -PI/64 per sample, wrap after sample 64
      load_cfo(102944);
      start(s);
      run(150);
      chk_smp("rot", s, 0, 1000, 0, 3);
      chk_smp("rot", s, 16, 707, -707, 3);
      chk_smp("rot", s, 32, 0, -1000, 3);
      chk_smp("rot", s, 64, -1000, 0, 3);
      chk_smp("rot", s, 96, 0, 1000, 3);
      chk_smp("rot", s, 128, 1000, 0, 3);

      // saturation: (2047,2047) rotated by -PI/4 and -3PI/4
      di_re = 12'sd2047;
      di_im = 12'sd2047;
      start(s);
      run(70);
      chk("sat_k16_re", ore(s + 16 + LAT), 2047, 0);
      chk("sat_k16_im", oim(s + 16 + LAT), 0, 3);
      chk("sat_k48_re", ore(s + 48 + LAT), 0, 3);
      chk("sat_k48_im", oim(s + 48 + LAT), -2048, 0);

      // restart at sample 500, then a full-length packet
      di_re = 12'sd1000;
      di_im = 12'sd0;
      start(s1);
      run(499);
      start(s2);
      run(MAX_LEN + 40);
      chk("rs_start2", osof(s2 + LAT), 1, 0);
      chk_smp("rs", s2, 0, 1000, 0, 2);
      nsof = 0;
      for (int i = s1 + LAT; i <= s2 + LAT; i++) nsof += osof(i);
      chk("rs_start_count", nsof, 2, 0);
      cnt = 0;
      for (int i = s2 + LAT; i < s2 + LAT + MAX_LEN + 20; i++) cnt += ovld(i);
      chk("len_vld_count", cnt, MAX_LEN, 0);
      chk("len_vld_last", ovld(s2 + LAT + MAX_LEN - 1), 1, 0);
      chk("len_vld_after", ovld(s2 + LAT + MAX_LEN), 0, 0);
      chk("len_re_after", ore(s2 + LAT + MAX_LEN), 0, 0);

      // mid-packet update: new cfo takes effect from sample 101
      load_cfo(0);
      start(s);
      run(98);
      cfo_estimated     = 18'sd51472;
      cfo_estimated_vld = 1'b1;
      step();
      cfo_estimated_vld = 1'b0;
      run(120);
      chk_smp("upd", s, 99, 1000, 0, 2);
      chk_smp("upd", s, 100, 1000, 0, 2);
      chk_smp("upd", s, 101, 1000, -25, 3);
      chk_smp("upd", s, 132, 707, -707, 3);
      chk_smp("upd", s, 164, 0, -1000, 3);

      // asynchronous reset mid-packet
      chk("mrst_vld_before", ovld(cyc - 1), 1, 0);
      rst = 1'b1;
      #2;
      chk("mrst_re", int'(do_re), 0, 0);
      chk("mrst_im", int'(do_im), 0, 0);
      chk("mrst_vld", int'(do_vld), 0, 0);
      chk("mrst_start", int'(do_start), 0, 0);
      step();
      step();
      rst  = 1'b0;
      base = cyc;
      run(40);
      cnt = 0;
      for (int i = base; i < cyc; i++) cnt += ovld(i) + osof(i) + ((ore(i) != 0) ? 1 : 0);
      chk("mrst_quiet", cnt, 0, 0);
      start(s);
      run(20);
      chk("mrst_vld_pre", ovld(s + LAT - 1), 0, 0);
      chk("mrst_restart", osof(s + LAT), 1, 0);
      chk_smp("mrst", s, 0, 1000, 0, 2);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/cfo_comp.md
Name: cfo_comp

Overview:
- Carrier Frequency Offset Compensation. Sits directly after the CFO estimator in the receive chain and consumes its delayed sample stream, its cs_start flag and its cfo_estimated/cfo_estimated_vld result.
- De-rotates each received sample by a linearly growing phase, sample k rotated by -k*cfo/N, using an internal pipelined rotation-mode CORDIC. No vendor IP.
- Feeds symbol sync and the FFT.

Parameters:
- N, 64: preamble repetition lag in samples, must be a power of two; the estimate is phase over N samples.
- LOG2N, 6: log2(N).
- STAGES, 14: CORDIC micro-rotation stages.
- MAX_LEN, 8192: samples processed per packet after cs_start.

Ports:
- clk  in  1  working clock
- rst  in  1  reset
- di_re  in  12  signed received sample, real part
- di_im  in  12  signed received sample, imaginary part
- cs_start  in  1  one-cycle pulse, marks the first sample to compensate (sample k=0)
- cfo_estimated  in  18  signed, 2Q15 radians, phase over N samples
- cfo_estimated_vld  in  1  one-cycle pulse, cfo_estimated valid
- do_re  out  12  signed compensated sample, real part
- do_im  out  12  signed compensated sample, imaginary part
- do_vld  out  1  output sample valid
- do_start  out  1  one-cycle pulse aligned with the output of sample k=0

Behaviour:
- Reset is rst, asynchronous, active-high; clock clk. All regs clear on reset, including the pipeline, state=IDLE and cfo_reg=0. Outputs reset to: do_re=0, do_im=0, do_vld=0, do_start=0.
- cfo_reg: loads cfo_estimated on the cycle after cfo_estimated_vld. An update mid-packet takes effect from the next sample; the accumulator is not reset.
- Phase increment: delta = -(sign-extended cfo_reg), kept with LOG2N extra fractional bits, giving an accumulator of width 18+LOG2N+1.
  - PI = 102944 << LOG2N; 2PI = 205887 << LOG2N.
- Phase accumulator:
  - Sample k is rotated by phi_k; phi_0 = 0; phi_{k+1} = wrap(phi_k + delta).
  - wrap: if the result > PI, subtract 2PI; if < -PI, add 2PI. A single correction suffices because |delta| <= PI.
  - The CORDIC angle is phi_k >> LOG2N, arithmetic shift, 2Q15.
- State machine:
  - IDLE: on cs_start go to ACTIVE, cnt=0, phi=0; the current di is sample 0.
  - ACTIVE: each cycle, process one sample and increment cnt. Return to IDLE after sample MAX_LEN-1.
  - cs_start while ACTIVE: restart, with cnt=0 and phi=0 at that same sample.
  - cs_start on the last sample: restart takes priority and the block stays ACTIVE.
- Pipeline, fixed latency of STAGES+3 = 17 cycles from di to do:
  - Stage 1: input register. Sign-extend to 16 bits; angle to 18 bits.
  - Stage 2: quadrant pre-rotation.
    - If angle > PI/2 (51472): (x,y) <- (-y,x), angle -= 51472.
    - If angle < -51472: (x,y) <- (y,-x), angle += 51472.
  - Stages 3..STAGES+2: micro-rotations. Stage i uses an arithmetic shift by i and the constant atan(2^-i) in 2Q15, rounded. Direction = sign of the residual angle.
  - Final stage: multiply x,y by 19899 (0.60725*2^15), add 2^14, arithmetic shift right by 15, then saturate to [-2048, 2047].
- Valid and start flags:
  - do_vld/do_start are the ACTIVE flag and the k=0 flag, delayed 17 cycles alongside the data.
  - do_re/do_im hold 0 when do_vld=0.
- A reset asserted mid-packet flushes the pipeline immediately. No partial outputs follow the deassertion of reset.
- Accuracy: with cfo_reg=0, output = input within ±2 LSB.

Test Plan:
- Reset: assert rst mid-stream -> do_re=do_im=0 and do_vld=do_start=0 in the same cycle, and they stay 0 until the next cs_start+17.
- Zero CFO: cfo pulse with value 0, then cs_start with constant input (1000,0) -> do_start 17 cycles later as a single pulse; do_re=1000±2, do_im=0±2 for all samples.
- Rotation and wrap, N=64, cfo_estimated=102944 (π): input (1000,0) -> the expected output at each sample is within ±3 LSB:
  - sample 32: (0,-1000)
  - sample 64: (-1000,0)
  - sample 96: (0,1000), correct after the wrap
  - sample 128: (1000,0)
- Saturation: cfo such that phi_1 = -π/4, input (2047,2047) -> sample 1 do_re=2047 (saturated), do_im=0±3; no sign flip.
- Restart and length:
  - cs_start again at sample 500 -> the output at that position equals the un-rotated input, and do_start pulses a second time.
  - Without a restart -> do_vld is high for exactly MAX_LEN cycles.
- Mid-packet CFO update: change cfo at sample 100 from 0 to 51472 -> sample 100 is unrotated, and the phase thereafter advances by -π/128 per sample starting from 0.
